// File: rtl/rle_row_encoder.sv
// Buffers one YUV422 row from an FWFT FIFO, then emits a sync word followed by
// (count, value) run pairs for the Y, U and V planes; output words hold under backpressure.
module rle_row_encoder #(
  parameter int ROW_PIXELS = 640,
  parameter int CH_W = 8,
  parameter int MAX_RUN = 255,
  parameter logic [CH_W-1:0] SYNC_WORD = CH_W'(8'hA5)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2*CH_W-1:0] i_pixel,
  input  logic              i_empty,
  output logic              o_fetch,
  output logic [CH_W-1:0]   o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_row_done
);
  localparam int HALF  = ROW_PIXELS / 2;
  localparam int PIX_W = $clog2(ROW_PIXELS + 1);
  localparam int ADR_W = $clog2(ROW_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_HDR, S_SCAN, S_EMIT_CNT, S_EMIT_VAL
  } state_t;

  state_t state_q, state_d;

  // Y plane in y_mem; chroma shares c_mem with U at [0, HALF) and V at [HALF, ROW_PIXELS).
  logic [CH_W-1:0] y_mem [0:ROW_PIXELS-1];
  logic [CH_W-1:0] c_mem [0:ROW_PIXELS-1];

  logic [PIX_W-1:0] pix_cnt;
  logic [1:0]       plane;
  logic [PIX_W-1:0] scan_idx;
  logic [PIX_W-1:0] cons;
  logic [CH_W-1:0]  rd_dat;
  logic             rd_vld;
  logic [CH_W-1:0]  run_val;
  logic [CH_W-1:0]  run_cnt;
  logic             row_done_q;

  logic [PIX_W-1:0] plane_len;
  logic             plane_end;
  logic             close_run;
  logic             take;
  logic             last_pix;
  logic             scan_adv;
  logic [ADR_W-1:0] y_waddr;
  logic [ADR_W-1:0] c_waddr;
  logic [ADR_W-1:0] rd_addr;

  assign plane_len = (plane == 2'd0) ? PIX_W'(ROW_PIXELS) : PIX_W'(HALF);
  assign plane_end = (cons == plane_len);
  assign last_pix  = (pix_cnt == PIX_W'(ROW_PIXELS - 1));

  // A run closes before consuming the entry that breaks it, so that entry starts the next run.
  assign close_run = (state_q == S_SCAN) && (run_cnt != '0) &&
                     (plane_end || (run_cnt == CH_W'(MAX_RUN)) ||
                      (rd_vld && (rd_dat != run_val)));
  assign take      = (state_q == S_SCAN) && rd_vld && !close_run;
  assign scan_adv  = (state_q == S_SCAN) && !close_run && (scan_idx != plane_len);

  assign y_waddr = ADR_W'(pix_cnt);
  assign c_waddr = ADR_W'(pix_cnt >> 1) + (pix_cnt[0] ? ADR_W'(HALF) : ADR_W'(0));
  assign rd_addr = ADR_W'(scan_idx) + ((plane == 2'd2) ? ADR_W'(HALF) : ADR_W'(0));

  assign o_busy     = (state_q != S_IDLE) && (state_q != S_FILL);
  assign o_row_done = row_done_q;

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_fetch = 1'b0;
    o_valid = 1'b0;
    o_data  = '0;
    case (state_q)
      S_IDLE: state_d = S_FILL;
      S_FILL: begin
        o_fetch = !i_empty;
        if (!i_empty && last_pix) state_d = S_HDR;
      end
      S_HDR: begin
        o_valid = 1'b1;
        o_data  = SYNC_WORD;
        if (i_ready) state_d = S_SCAN;
      end
      S_SCAN: if (close_run) state_d = S_EMIT_CNT;
      S_EMIT_CNT: begin
        o_valid = 1'b1;
        o_data  = run_cnt;
        if (i_ready) state_d = S_EMIT_VAL;
      end
      S_EMIT_VAL: begin
        o_valid = 1'b1;
        o_data  = run_val;
        if (i_ready) state_d = (plane_end && (plane == 2'd2)) ? S_FILL : S_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pix_cnt    <= '0;
      plane      <= '0;
      scan_idx   <= '0;
      cons       <= '0;
      rd_vld     <= 1'b0;
      run_val    <= '0;
      run_cnt    <= '0;
      row_done_q <= 1'b0;
    end else begin
      row_done_q <= 1'b0;
      rd_vld     <= scan_adv;
      if (o_fetch) pix_cnt <= last_pix ? '0 : pix_cnt + PIX_W'(1);
      if (scan_adv) scan_idx <= scan_idx + PIX_W'(1);
      if (take) begin
        cons    <= cons + PIX_W'(1);
        run_cnt <= run_cnt + CH_W'(1);
        if (run_cnt == '0) run_val <= rd_dat;
      end
      if ((state_q == S_HDR) && i_ready) begin
        plane    <= '0;
        cons     <= '0;
        scan_idx <= '0;
        run_cnt  <= '0;
      end
      // Rewind the read pointer to the first unconsumed entry, or move on to the next plane.
      if ((state_q == S_EMIT_VAL) && i_ready) begin
        run_cnt <= '0;
        if (plane_end) begin
          cons       <= '0;
          scan_idx   <= '0;
          plane      <= (plane == 2'd2) ? 2'd0 : plane + 2'd1;
          row_done_q <= (plane == 2'd2);
        end else begin
          scan_idx <= cons;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (o_fetch) begin
      y_mem[y_waddr] <= i_pixel[2*CH_W-1:CH_W];
      c_mem[c_waddr] <= i_pixel[CH_W-1:0];
    end
    rd_dat <= (plane == 2'd0) ? y_mem[rd_addr] : c_mem[rd_addr];
  end

endmodule

// File: tb/tb_rle_row_encoder.sv
// Bench for rle_row_encoder (8-pixel rows): table of rows with expected byte streams,
// scoreboard compare on every transfer, plus reset and mid-row reset sequences.
module tb_rle_row_encoder;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic [15:0] i_pixel;
  logic        i_empty_a, i_empty_b;
  logic        i_ready;
  logic        a_fetch, a_valid, a_busy, a_done;
  logic        b_fetch, b_valid, b_busy, b_done;
  logic [7:0]  a_data, b_data;

  // Instance a: default run cap. Instance b: run cap of 3.
  rle_row_encoder #(.ROW_PIXELS(8), .CH_W(8), .MAX_RUN(255)) dut_a (
    .CLK(CLK), .RST(RST), .i_pixel(i_pixel), .i_empty(i_empty_a), .o_fetch(a_fetch),
    .o_data(a_data), .o_valid(a_valid), .i_ready(i_ready), .o_busy(a_busy),
    .o_row_done(a_done));

  rle_row_encoder #(.ROW_PIXELS(8), .CH_W(8), .MAX_RUN(3)) dut_b (
    .CLK(CLK), .RST(RST), .i_pixel(i_pixel), .i_empty(i_empty_b), .o_fetch(b_fetch),
    .o_data(b_data), .o_valid(b_valid), .i_ready(i_ready), .o_busy(b_busy),
    .o_row_done(b_done));

  bit sel;
  logic       m_fetch, m_valid, m_busy, m_done;
  logic [7:0] m_data;
  assign m_fetch = sel ? b_fetch : a_fetch;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_data  = sel ? b_data  : a_data;

  typedef struct packed {
    logic [127:0] pix;
    logic [319:0] exp;
    logic [7:0]   n;
    logic         cap;
    logic         starve;
    logic         bp;
    logic         rnd;
  } vec_t;

  vec_t vecs [7];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  sb[$];
  logic [15:0] pix_q[$];
  bit starve, starve_ph, rnd, bp_arm, exp_done, finished, prev_stall;
  int bp_cnt, words_seen, abort_after;
  logic [7:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic emp, xfer, fetch;
    logic [7:0] data, exp_b;
    @(negedge CLK);
    starve_ph = !starve_ph;
    emp = (pix_q.size() == 0) || (starve && starve_ph);
    i_pixel = (pix_q.size() != 0) ? pix_q[0] : 16'h0000;
    i_empty_a = sel ? 1'b1 : emp;
    i_empty_b = sel ? emp : 1'b1;
    #1;
    if (bp_arm && (words_seen == 1) && m_valid) begin
      bp_cnt = 5;
      bp_arm = 1'b0;
    end
    if (bp_cnt > 0) begin
      i_ready = 1'b0;
      bp_cnt--;
    end else if (rnd) begin
      i_ready = 1'($urandom_range(0, 1));
    end else begin
      i_ready = 1'b1;
    end
    #1;
    if (m_done || exp_done) begin
      chk("row_done", 32'(m_done), 32'(exp_done));
      if (exp_done) finished = 1'b1;
      exp_done = 1'b0;
    end
    if (prev_stall) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(prev_data));
    end
    if (emp) chk("fetch_when_empty", 32'(m_fetch), 32'd0);
    if (m_fetch) chk("busy_in_fill", 32'(m_busy), 32'd0);
    if (m_valid) chk("busy_in_emit", 32'(m_busy), 32'd1);
    prev_stall = m_valid && !i_ready;
    prev_data  = m_data;
    xfer  = m_valid && i_ready;
    fetch = m_fetch;
    data  = m_data;
    @(posedge CLK);
    if (fetch && (pix_q.size() != 0)) void'(pix_q.pop_front());
    if (xfer) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL word_extra: got %02h, none expected", data);
      end else begin
        exp_b = sb.pop_front();
        chk($sformatf("word%0d", words_seen), 32'(data), 32'(exp_b));
        if ((sb.size() == 0) && (abort_after == 0)) exp_done = 1'b1;
      end
      words_seen++;
      if ((abort_after != 0) && (words_seen == abort_after)) finished = 1'b1;
    end
  endtask

  task automatic run_row(input vec_t v, input int abort);
    sel = v.cap;
    starve = v.starve;
    rnd = v.rnd;
    bp_arm = v.bp;
    bp_cnt = 0;
    words_seen = 0;
    finished = 1'b0;
    exp_done = 1'b0;
    prev_stall = 1'b0;
    abort_after = abort;
    for (int i = 0; i < 8; i++) pix_q.push_back(v.pix[i*16 +: 16]);
    for (int k = 0; k < int'(v.n); k++) sb.push_back(v.exp[(int'(v.n) - 1 - k)*8 +: 8]);
    for (int c = 0; (c < 600) && !finished; c++) step();
    chk("row_complete", 32'(finished), 32'd1);
    if (abort == 0) chk("pixels_consumed", 32'(pix_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    i_ready = 1'b0;
    i_empty_a = 1'b0;
    i_empty_b = 1'b0;
    i_pixel = 16'hFFFF;
    @(posedge CLK);
    #1;
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_data",  32'(a_data),  32'd0);
    chk("rst_a_done",  32'(a_done),  32'd0);
    chk("rst_a_busy",  32'(a_busy),  32'd0);
    chk("rst_a_fetch", 32'(a_fetch), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_b_data",  32'(b_data),  32'd0);
    chk("rst_b_busy",  32'(b_busy),  32'd0);
    chk("rst_b_fetch", 32'(b_fetch), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    i_empty_a = 1'b1;
    i_empty_b = 1'b1;
    pix_q.delete();
    sb.delete();
    prev_stall = 1'b0;
    exp_done = 1'b0;
    bp_cnt = 0;
  endtask

  initial begin
    RST = 1'b0;
    i_ready = 1'b0;
    i_empty_a = 1'b1;
    i_empty_b = 1'b1;
    i_pixel = 16'h0000;
    sel = 1'b0;
    starve = 1'b0;
    starve_ph = 1'b0;
    rnd = 1'b0;
    bp_arm = 1'b0;
    abort_after = 0;

    vecs[0] = '{pix: {8{16'h1080}},
                exp: 320'({8'hA5, 8'h08, 8'h10, 8'h04, 8'h80, 8'h04, 8'h80}),
                n: 8'd7, cap: 1'b0, starve: 1'b0, bp: 1'b0, rnd: 1'b0};
    vecs[1] = '{pix: {8{16'h1080}},
                exp: 320'({8'hA5, 8'h03, 8'h10, 8'h03, 8'h10, 8'h02, 8'h10,
                           8'h03, 8'h80, 8'h01, 8'h80, 8'h03, 8'h80, 8'h01, 8'h80}),
                n: 8'd15, cap: 1'b1, starve: 1'b0, bp: 1'b0, rnd: 1'b0};
    vecs[2] = '{pix: {4{16'h2080, 16'h1080}},
                exp: 320'({8'hA5, {4{8'h01, 8'h10, 8'h01, 8'h20}},
                           8'h04, 8'h80, 8'h04, 8'h80}),
                n: 8'd21, cap: 1'b0, starve: 1'b0, bp: 1'b0, rnd: 1'b0};
    vecs[3] = vecs[0];
    vecs[3].bp = 1'b1;
    vecs[4] = vecs[0];
    vecs[4].starve = 1'b1;
    // Pixels 7..0: Y 11,11,11,22,22,33,33,33; U 40,40,41,41; V 50,51,51,51.
    vecs[5] = '{pix: {16'h3351, 16'h3341, 16'h3351, 16'h2241,
                      16'h2251, 16'h1140, 16'h1150, 16'h1140},
                exp: 320'({8'hA5, 8'h03, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33,
                           8'h02, 8'h40, 8'h02, 8'h41, 8'h01, 8'h50, 8'h03, 8'h51}),
                n: 8'd15, cap: 1'b0, starve: 1'b0, bp: 1'b0, rnd: 1'b1};
    vecs[6] = '{pix: {8{16'h3070}},
                exp: 320'({8'hA5, 8'h08, 8'h30, 8'h04, 8'h70, 8'h04, 8'h70}),
                n: 8'd7, cap: 1'b0, starve: 1'b0, bp: 1'b0, rnd: 1'b0};

    do_reset();
    for (int i = 0; i < 6; i++) run_row(vecs[i], 0);

    // Abort a row after its second word, then a fresh row must come out clean.
    run_row(vecs[0], 2);
    do_reset();
    run_row(vecs[6], 0);
    for (int i = 0; i < 4; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rle_row_encoder.md
RLE_ROW_ENCODER -- requirements
Module: rle_row_encoder

Interface
REQ-001 SHALL have parameter ROW_PIXELS, default 640, meaning pixels per row; even, >= 2.
REQ-002 SHALL have parameter CH_W, default 8, meaning channel width in bits; pixel width is 2*CH_W (YUV422: Y in upper half, chroma in lower half).
REQ-003 SHALL have parameter MAX_RUN, default 255, meaning maximum run length per pair; legal range 1 .. 2^CH_W-1.
REQ-004 SHALL have parameter SYNC_WORD, default 8'hA5 zero-extended to CH_W, meaning the row header word.
REQ-005 CLK  input  1  clock; all state changes on its rising edge.
REQ-006 RST  input  1  reset; synchronous, active-low.
REQ-007 i_pixel  input  2*CH_W  pixel from the FWFT FIFO head.
REQ-008 i_empty  input  1  FIFO empty flag.
REQ-009 o_fetch  output  1  combinational pop; a pixel is consumed in the cycle where o_fetch=1.
REQ-010 o_data  output  CH_W  encoded output word.
REQ-011 o_valid  output  1  o_data is valid.
REQ-012 i_ready  input  1  sink (UART) accepts a word; a transfer occurs when o_valid=1 and i_ready=1.
REQ-013 o_busy  output  1  high in every state except IDLE and FILL.
REQ-014 o_row_done  output  1  one-cycle pulse after the last word of a row transfers.

Function
REQ-015 SHALL implement states IDLE, FILL, HDR, SCAN, EMIT_CNT, EMIT_VAL; IDLE goes to FILL one cycle after reset release.
REQ-016 FILL: o_fetch = !i_empty.
- Per fetched pixel n: Y[n] = upper half.
- Even n: U[n/2] = lower half; odd n: V[(n-1)/2] = lower half.
- Pixel counter width = clog2(ROW_PIXELS+1).
REQ-017 After pixel ROW_PIXELS-1 is fetched, the block SHALL enter HDR; o_fetch = 0 in all states other than FILL (input is stalled, never dropped).
REQ-018 HDR SHALL present o_data=SYNC_WORD with o_valid=1 until transferred, then enter SCAN on plane Y.
REQ-019 SCAN:
- Planes encode in order Y (ROW_PIXELS entries), U (ROW_PIXELS/2), V (ROW_PIXELS/2).
- Buffer reads have 1-cycle latency.
- A run extends while the next entry equals the run value and the count is < MAX_RUN.
REQ-020 A run SHALL close on a value change, count == MAX_RUN, or plane end, and the block then emits EMIT_CNT (o_data = count, 1..MAX_RUN), then EMIT_VAL (o_data = value).
REQ-021 After the EMIT_VAL transfer, the block SHALL resume SCAN at the entry following the run, or start the next plane at plane end; runs never cross planes.
REQ-022 After the final V pair transfers, o_row_done SHALL pulse for 1 cycle and the state SHALL return to FILL.
REQ-023 While o_valid=1 and i_ready=0, o_data and o_valid SHALL hold stable; o_valid SHALL drop in the cycle after a transfer unless the next word is ready.
REQ-024 o_valid SHALL never be asserted in IDLE, FILL or SCAN.
REQ-025 Throughput SHALL be at most 1 word per cycle; SCAN overhead is at most 2 cycles per run.

Reset
REQ-026 On RST=0 at a clock edge, the block SHALL enter IDLE with o_valid=0, o_data=0, o_row_done=0, o_busy=0, o_fetch=0, and all counters 0.
REQ-027 Reset mid-row (FILL or any emit state) SHALL discard partial row data and partial output words; no word is completed after reset.
REQ-028 Buffer contents SHALL need no reset; stale data is never emitted, because FILL always overwrites all entries before HDR.

Verification (ROW_PIXELS=8, CH_W=8, i_ready=1 unless stated)
REQ-029 Uniform row: 8 pixels 0x1080 -> A5, 08 10, 04 80, 04 80, then o_row_done pulse.
REQ-030 Run cap: MAX_RUN=3, 8 pixels 0x1080 -> A5, 03 10, 03 10, 02 10, 03 80, 01 80, 03 80, 01 80.
REQ-031 Alternating Y 0x10/0x20, chroma 0x80 -> A5, then 8 pairs 01 10 / 01 20 alternating, then 04 80, 04 80.
REQ-032 Backpressure: drop i_ready for 5 cycles during EMIT_CNT -> o_data and o_valid stable; byte sequence identical to REQ-029.
REQ-033 Starved FIFO: i_empty toggles every cycle during FILL -> only cycles with i_empty=0 fetch; output identical to REQ-029.
REQ-034 Reset after the 2nd output word, then a new uniform row of 0x3070 -> A5, 08 30, 04 70, 04 70, with no remnant of the first row.
